uart_fifoed_send_param: RTL and testbench
=========================================

// Module: uart_fifoed_send_param
// PURPOSE
//  Parametrised FIFO-buffered UART transmitter; next generation of the fixed 8N1/128-entry sender.
//  Adds configurable baud divisor, data width, parity and stop bits, FIFO depth/threshold, a pause input, status outputs.
//  Sits between the CPU I/O write port (dat/dat_en) and the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per UART bit (100 MHz / 115200); >= 2
//  DATA_BITS     8    data bits per frame, 5..8, LSB first
//  PARITY_MODE   0    0 none, 1 even, 2 odd
//  STOP_BITS     1    1 or 2
//  FIFO_DEPTH    128  entries, power of 2, >= 4
//  AFULL_THRESH  122  fifo_afull asserted when level >= AFULL_THRESH (< FIFO_DEPTH)
// PORTS
//  clk_100MHz   in   1                       system clock, all logic on rising edge
//  reset        in   1                       asynchronous, active-high
//  dat_en       in   1                       push request, one byte per cycle high
//  dat          in   8                       byte to push; bits [DATA_BITS-1:0] transmitted
//  tx_enable    in   1                       1 = frames may start; 0 = pause after current frame
//  TX           out  1                       serial line, idle high
//  fifo_empty   out  1                       level == 0
//  fifo_afull   out  1                       level >= AFULL_THRESH
//  fifo_full    out  1                       level == FIFO_DEPTH
//  fifo_level   out  $clog2(FIFO_DEPTH)+1    current entry count
//  busy         out  1                       FSM not in IDLE
//  tx_done      out  1                       one-cycle pulse, last stop bit's final cycle
//  overflow     out  1                       one-cycle pulse, push rejected because full
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): TX=1 immediately; FIFO cleared (pointers/level 0); FSM IDLE;
//   fifo_empty=1, fifo_afull=0, fifo_full=0, fifo_level=0, busy=0, tx_done=0, overflow=0; baud counter 0.
//  FIFO: register array, pointers wrap FIFO_DEPTH-1 -> 0; head readable combinationally.
//   Push accepted when dat_en && level < FIFO_DEPTH (registered level); else dropped, overflow=1 next cycle.
//   Pop occurs only in IDLE when level > 0 && tx_enable; head byte loaded into shifter same edge.
//   Simultaneous accepted push and pop: level unchanged, both pointers advance.
//   Push into empty FIFO: visible to FSM next cycle (no write-through in same cycle).
//   Status outputs are registered/derived from registered level; update the cycle after the push/pop edge.
//  FSM states: IDLE -> START -> DATA -> [PARITY if PARITY_MODE!=0] -> STOP -> IDLE.
//   IDLE: TX=1; pop condition true -> START, baud counter loaded CLKS_PER_BIT-1.
//   Each non-IDLE state holds TX for exactly CLKS_PER_BIT cycles; counter counts down, advance at 0.
//   START TX=0; DATA shifts DATA_BITS bits LSB first; PARITY TX = XOR(data) (even) or ~XOR(data) (odd);
//   STOP TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  Timing: TX falls the cycle after the pop edge; frame = CLKS_PER_BIT*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)
//   cycles; exactly one IDLE cycle (TX=1) between back-to-back frames.
//  tx_enable=0 never aborts a frame; only blocks the next pop. Re-assert -> pop on next IDLE cycle.
//  dat bits above DATA_BITS-1 ignored (not transmitted, not in parity).
//  busy=1 from START entry through final STOP cycle.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=8, AFULL_THRESH=6 unless stated)
//  8N1: push 0xA5 once -> TX: 1 idle cycle, 0 x4, bits 1,0,1,0,0,1,0,1 x4 each, 1 x4; tx_done once; fifo_empty=1 at end.
//  Parity/stop: PARITY_MODE=2, STOP_BITS=2, DATA_BITS=7, push 0x83 -> data 1100000, parity 1, stop 8 cycles, frame 44 cycles.
//  Fill: tx_enable=0, push 9 bytes back-to-back -> afull at level 6, full at 8, overflow pulse on 9th, level stays 8.
//  Back-to-back: push 3 bytes, tx_enable=1 -> 3 frames of 40 cycles, exactly one idle cycle between, contents in order.
//  Wrap + simultaneous: stream 20 bytes while transmitting, push during each pop cycle -> level constant, byte order kept.
//  Reset mid-frame: assert reset during DATA bit 3 -> TX=1 same cycle, level=0, no tx_done; new push after release transmits normally.

Source files
------------

// File: rtl/uart_fifoed_send_param.sv
// Parametrised FIFO-buffered UART transmitter: configurable baud divisor,
// frame format (data/parity/stop), FIFO depth and almost-full threshold.
module uart_fifoed_send_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 128,
    parameter int AFULL_THRESH = 122
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic                          dat_en,
    input  logic [7:0]                    dat,
    input  logic                          tx_enable,
    output logic                          TX,
    output logic                          fifo_empty,
    output logic                          fifo_afull,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AFULL_L   = LW'(AFULL_THRESH);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_MODE == 2);
    localparam logic          HAS_PAR   = (PARITY_MODE != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 overflow_q, overflow_d;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;

    logic                 push;
    logic                 pop;
    logic                 cnt_zero;
    logic [DATA_BITS-1:0] head;
    logic                 unused_dat;

    // Upper dat bits are deliberately dropped for narrow frames.
    assign unused_dat = ^dat;

    assign head     = mem_q[rd_ptr_q];
    assign push     = dat_en && (level_q != DEPTH_L);
    assign pop      = (state_q == S_IDLE) && (level_q != '0) && tx_enable;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = dat_en && !push;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dat[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // TX is registered from the next state so it changes with the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        if (state_q != S_IDLE) begin
            cnt_d = cnt_zero ? CNT_MAX : cnt_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d  = S_START;
                    cnt_d    = CNT_MAX;
                    shift_d  = head;
                    parity_d = (^head) ^ PAR_ODD;
                    tx_d     = 1'b0;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    if (bit_idx_q == LAST_BIT) begin
                        if (HAS_PAR) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (cnt_zero) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (cnt_zero) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

    assign TX         = tx_q;
    assign fifo_level = level_q;
    assign fifo_empty = (level_q == '0);
    assign fifo_afull = (level_q >= AFULL_L);
    assign fifo_full  = (level_q == DEPTH_L);
    assign busy       = (state_q != S_IDLE);
    assign overflow   = overflow_q;
    assign tx_done    = (state_q == S_STOP) && cnt_zero
                        && (stop_idx_q == STOP_LAST);

endmodule

// File: tb/tb_uart_fifoed_send_param.sv
// Scoreboard bench: instance A is 8N1, instance B is 7 data / odd / 2 stop,
// both with 4 clocks per bit and an 8-deep FIFO.
module tb_uart_fifoed_send_param;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] d;
        int         gap;
        bit         abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, tx_en_a, en_b, tx_en_b;
    logic [7:0] dat_a, dat_b;
    logic       tx_a, empty_a, afull_a, full_a, busy_a, done_a, ovf_a;
    logic       tx_b, empty_b, afull_b, full_b, busy_b, done_b, ovf_b;
    logic [3:0] level_a, level_b;

    exp_t qa[$];
    exp_t qb[$];
    bit   act_a = 1'b0;
    bit   act_b = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_fifoed_send_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
        .STOP_BITS(1), .FIFO_DEPTH(8), .AFULL_THRESH(6)
    ) dut_a (
        .clk_100MHz(clk), .reset(rst), .dat_en(en_a), .dat(dat_a),
        .tx_enable(tx_en_a), .TX(tx_a), .fifo_empty(empty_a),
        .fifo_afull(afull_a), .fifo_full(full_a), .fifo_level(level_a),
        .busy(busy_a), .tx_done(done_a), .overflow(ovf_a)
    );

    uart_fifoed_send_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2),
        .STOP_BITS(2), .FIFO_DEPTH(8), .AFULL_THRESH(6)
    ) dut_b (
        .clk_100MHz(clk), .reset(rst), .dat_en(en_b), .dat(dat_b),
        .tx_enable(tx_en_b), .TX(tx_b), .fifo_empty(empty_b),
        .fifo_afull(afull_b), .fifo_full(full_b), .fifo_level(level_b),
        .busy(busy_b), .tx_done(done_b), .overflow(ovf_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line level for frame bit slot idx (0 = start bit).
    function automatic logic exp_bit(input logic [7:0] d, input int nb,
                                     input int pm, input int idx);
        logic p;
        p = 1'b0;
        if (idx == 0) return 1'b0;
        if (idx <= nb) return d[idx-1];
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        if (pm != 0 && idx == nb + 1) return (pm == 2) ? ~p : p;
        return 1'b1;
    endfunction

    task automatic monitor(input int id);
        exp_t cur;
        int   mc, idle, err, idle_err, nb, pm, sb, flen;
        logic tx, bz, dn;
        mc = -1; idle = -1000; err = 0; idle_err = 0;
        nb = (id == 0) ? 8 : 7;
        pm = (id == 0) ? 0 : 2;
        sb = (id == 0) ? 1 : 2;
        flen = CPB * (1 + nb + ((pm != 0) ? 1 : 0) + sb);
        cur = '{d: 8'h00, gap: -1, abort: 1'b0};
        forever begin
            @(negedge clk);
            tx = (id == 0) ? tx_a : tx_b;
            bz = (id == 0) ? busy_a : busy_b;
            dn = (id == 0) ? done_a : done_b;
            if (rst) begin
                if (mc >= 0)
                    check($sformatf("abort%0d", id), 32'(cur.abort), 1);
                mc = -1; idle = -1000; idle_err = 0;
            end else begin
                if (mc < 0) begin
                    if (tx) begin
                        idle++;
                        if (bz || dn) idle_err++;
                    end else begin
                        if ((id == 0 ? qa.size() : qb.size()) == 0) begin
                            check($sformatf("unexpected_frame%0d", id), 1, 0);
                            cur = '{d: 8'h00, gap: -1, abort: 1'b0};
                        end else if (id == 0) begin
                            cur = qa.pop_front();
                        end else begin
                            cur = qb.pop_front();
                        end
                        check($sformatf("idle_flags%0d", id), idle_err, 0);
                        if (cur.gap >= 0)
                            check($sformatf("gap%0d_%02h", id, cur.d),
                                  idle, cur.gap);
                        idle_err = 0; mc = 0; err = 0;
                    end
                end
                if (mc >= 0) begin
                    if (tx !== exp_bit(cur.d, nb, pm, mc / CPB)) err++;
                    if (bz !== 1'b1) err++;
                    if (dn !== (mc == flen - 1)) err++;
                    mc++;
                    if (mc == flen) begin
                        check($sformatf("frame%0d_%02h", id, cur.d),
                              err + (cur.abort ? 1000 : 0), 0);
                        mc = -1; idle = 0;
                    end
                end
            end
            if (id == 0) act_a = (mc >= 0);
            else act_b = (mc >= 0);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic push_a(input logic [7:0] b);
        dat_a = b; en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
    endtask

    task automatic drain(input int id);
        int b;
        b = 0;
        while (b < 3000 && ((id == 0)
               ? (qa.size() != 0 || act_a || busy_a)
               : (qb.size() != 0 || act_b || busy_b))) begin
            @(posedge clk); #1;
            b++;
        end
        check($sformatf("drain%0d_timeout", id), 32'(b >= 3000), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en_a = 1'b0; dat_a = '0; tx_en_a = 1'b0;
        en_b = 1'b0; dat_b = '0; tx_en_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx_a, 1);
        check("rst_empty", empty_a, 1);
        check("rst_afull", afull_a, 0);
        check("rst_full", full_a, 0);
        check("rst_level", level_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", ovf_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 8N1 single byte, pop latency
        tx_en_a = 1'b1;
        qa.push_back('{d: 8'hA5, gap: -1, abort: 1'b0});
        push_a(8'hA5);
        check("t1_idle_tx", tx_a, 1);
        check("t1_level1", level_a, 1);
        check("t1_empty0", empty_a, 0);
        @(posedge clk); #1;
        check("t1_start_tx", tx_a, 0);
        check("t1_busy", busy_a, 1);
        check("t1_level0", level_a, 0);
        drain(0);
        check("t1_empty_end", empty_a, 1);

        // odd parity, 7 data bits, 2 stop; bit 7 must be ignored
        tx_en_b = 1'b1;
        qb.push_back('{d: 8'h83, gap: -1, abort: 1'b0});
        dat_b = 8'h83; en_b = 1'b1;
        @(posedge clk); #1;
        en_b = 1'b0;
        drain(1);

        // fill with transmitter paused, then release back-to-back
        tx_en_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            int lvl;
            dat_a = 8'(8'h30 + i); en_a = 1'b1;
            if (i < 8)
                qa.push_back('{d: 8'(8'h30 + i), gap: (i == 0) ? -1 : 1,
                               abort: 1'b0});
            @(posedge clk); #1;
            lvl = (i < 8) ? i + 1 : 8;
            check($sformatf("fill%0d_level", i), level_a, lvl);
            check($sformatf("fill%0d_afull", i), afull_a, 32'(lvl >= 6));
            check($sformatf("fill%0d_full", i), full_a, 32'(lvl == 8));
            check($sformatf("fill%0d_ovf", i), ovf_a, 32'(i == 8));
        end
        en_a = 1'b0;
        @(posedge clk); #1;
        check("fill_ovf_pulse", ovf_a, 0);
        check("fill_level_hold", level_a, 8);
        tx_en_a = 1'b1;
        drain(0);

        // streaming with a push in every pop cycle, pointers wrap
        tx_en_a = 1'b0;
        qa.push_back('{d: 8'h40, gap: -1, abort: 1'b0});
        push_a(8'h40);
        qa.push_back('{d: 8'h41, gap: 1, abort: 1'b0});
        push_a(8'h41);
        tx_en_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int b;
            logic [3:0] lvl;
            b = 0;
            while (!(busy_a == 1'b0 && level_a != 0) && b < 100) begin
                @(posedge clk); #1;
                b++;
            end
            check("stream_wait", 32'(b >= 100), 0);
            dat_a = 8'(8'h50 + 3 * i); en_a = 1'b1;
            qa.push_back('{d: 8'(8'h50 + 3 * i), gap: 1, abort: 1'b0});
            lvl = level_a;
            @(posedge clk); #1;
            en_a = 1'b0;
            check($sformatf("stream%0d_level", i), level_a, lvl);
        end
        drain(0);

        // reset during data bit 3 of a frame, second byte queued
        qa.push_back('{d: 8'h34, gap: -1, abort: 1'b1});
        push_a(8'h34);
        push_a(8'hC7);
        check("rstmid_busy", busy_a, 1);
        check("rstmid_level", level_a, 1);
        repeat (17) @(posedge clk);
        #1;
        check("rstmid_pre_tx", tx_a, 0);
        rst = 1'b1;
        #1;
        check("rstmid_tx", tx_a, 1);
        check("rstmid_level0", level_a, 0);
        check("rstmid_busy0", busy_a, 0);
        check("rstmid_done", done_a, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid_empty", empty_a, 1);
        qa.push_back('{d: 8'h5A, gap: -1, abort: 1'b0});
        push_a(8'h5A);
        drain(0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
